// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the cache request arbiter.
package cache_arb_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_STB_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CHECK,
    WAIT_FILL
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] wdata;
    logic [CPU_STB_W-1:0]  wstb;
  } arb_req_t;

  // The cache only understands whole words, so the byte offset is dropped.
  function automatic logic [CPU_ADDR_W-1:0] word_align(input logic [CPU_ADDR_W-1:0] addr);
    return addr & ~CPU_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin sharing of the cache CPU port with miss replay and bounded retries.
// Define CACHE_ARB_STATS_EN to add saturating hit/miss/error counters.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  input  logic [NUM_REQ*4-1:0]    req_wstb,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [CPU_DATA_W-1:0]   rsp_rdata,
  output logic                    rsp_miss,
  output logic                    rsp_err,
  output logic [CPU_ADDR_W-1:0]   cpu_addr,
  output logic [CPU_DATA_W-1:0]   cpu_data_in,
  output logic                    cpu_we,
  output logic                    cpu_re,
  output logic [CPU_STB_W-1:0]    cpu_wstb,
  input  logic [CPU_DATA_W-1:0]   cpu_data_out,
  input  logic                    miss
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [15:0]             stat_errs
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  arb_state_e          state, state_nxt;
  logic [PW-1:0]       rr_ptr;
  logic [RW-1:0]       retry_cnt;
  arb_req_t            lat;
  arb_req_t            sel_req;
  logic [NUM_REQ-1:0]  owner;
  logic [NUM_REQ-1:0]  grant;
  logic [PW-1:0]       grant_idx;
  logic                any_grant;
  logic                take;
  logic                replay;
  logic                run;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_grant)
  );

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_req.we    = req_we[i];
        sel_req.addr  = req_addr[i*CPU_ADDR_W +: CPU_ADDR_W];
        sel_req.wdata = req_wdata[i*CPU_DATA_W +: CPU_DATA_W];
        sel_req.wstb  = req_wstb[i*CPU_STB_W +: CPU_STB_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    rsp_miss    = 1'b0;
    rsp_err     = 1'b0;
    cpu_addr    = '0;
    cpu_data_in = '0;
    cpu_we      = 1'b0;
    cpu_re      = 1'b0;
    cpu_wstb    = '0;
    take        = 1'b0;
    replay      = 1'b0;
    unique case (state)
      IDLE: begin
        if (run && any_grant && !miss) begin
          take      = 1'b1;
          req_ready = grant;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cpu_addr    = word_align(lat.addr);
        cpu_data_in = lat.wdata;
        cpu_we      = lat.we;
        cpu_re      = !lat.we;
        cpu_wstb    = lat.we ? lat.wstb : '0;
        state_nxt   = CHECK;
      end
      CHECK: begin
        if (!miss) begin
          rsp_valid = owner;
          rsp_rdata = lat.we ? '0 : cpu_data_out;
          rsp_miss  = (retry_cnt != '0);
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_FILL;
        end
      end
      WAIT_FILL: begin
        if (!miss) begin
          if (retry_cnt == MAX_R) begin
            rsp_valid = owner;
            rsp_miss  = 1'b1;
            rsp_err   = 1'b1;
            state_nxt = IDLE;
          end else begin
            replay    = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // run holds off grants until the first edge after reset release, so req_ready stays low in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run       <= 1'b0;
      rr_ptr    <= '0;
      retry_cnt <= '0;
      lat       <= '0;
      owner     <= '0;
    end else begin
      run <= 1'b1;
      if (take) begin
        lat       <= sel_req;
        owner     <= grant;
        retry_cnt <= '0;
        rr_ptr    <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      end else if (replay) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
    end
  end

`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_errs   <= '0;
    end else if (|rsp_valid) begin
      if (!rsp_miss && stat_hits != '1)  stat_hits   <= stat_hits + 32'd1;
      if (rsp_miss && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      if (rsp_err && stat_errs != '1)    stat_errs   <= stat_errs + 16'd1;
    end
  end
`endif

endmodule
